// File: rtl/car_link_responder_if.sv
// Serial link pins, detector inputs and decoded command levels of the vehicle-side responder.
// rx_dbg / tx_dbg mirror the RX and TX state registers (0 = IDLE, 1 = START, 2 = DATA, 3 = STOP).
interface car_link_responder_if;
  logic       rxd;
  logic       txd;
  logic [3:0] detector;
  logic [3:0] moving_state;
  logic       place_barrier;
  logic       destroy_barrier;
  logic       cmd_valid;
  logic       frame_err;
  logic       hdr_err;
  logic       tx_busy;
  logic [1:0] rx_dbg;
  logic [1:0] tx_dbg;

  modport master (
    output rxd, detector,
    input  txd, moving_state, place_barrier, destroy_barrier,
    input  cmd_valid, frame_err, hdr_err, tx_busy, rx_dbg, tx_dbg
  );

  modport slave (
    input  rxd, detector,
    output txd, moving_state, place_barrier, destroy_barrier,
    output cmd_valid, frame_err, hdr_err, tx_busy, rx_dbg, tx_dbg
  );
endinterface

// File: rtl/car_link_responder.sv
// Vehicle-side end of the car-control UART link: decodes 8N1 command bytes into held
// control levels and returns the 4-bit detector status periodically and on every change.
module car_link_responder #(
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUD          = 9600,
  parameter int STATUS_PERIOD = 1000000
) (
  input logic                 sys_clk,
  input logic                 rst,
  car_link_responder_if.slave link
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);
  localparam int PW       = $clog2(STATUS_PERIOD + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(STATUS_PERIOD - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- RX ----------------
  rx_state_t     rx_state, rx_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;
  logic          rx_fall;
  logic          rx_cnt_clr, rx_shift, rx_accept, rx_ferr, rx_herr;
  logic [3:0]    moving_q;
  logic          place_q, destroy_q;
  logic          cmd_valid_q, frame_err_q, hdr_err_q;

  assign rx_fall = rx_prev & ~rx_sync;

  always_comb begin
    rx_next    = rx_state;
    rx_cnt_clr = 1'b0;
    rx_shift   = 1'b0;
    rx_accept  = 1'b0;
    rx_ferr    = 1'b0;
    rx_herr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_next    = RX_START;
          rx_cnt_clr = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_clr = 1'b1;
          if (!rx_sync) rx_next = RX_DATA;
          else begin
            rx_ferr = 1'b1;
            rx_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_clr = 1'b1;
          rx_shift   = 1'b1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_clr = 1'b1;
          rx_next    = RX_IDLE;
          if (!rx_sync)                   rx_ferr   = 1'b1;
          else if (rx_byte[7:6] == 2'b10) rx_accept = 1'b1;
          else                            rx_herr   = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_byte     <= '0;
      moving_q    <= '0;
      place_q     <= 1'b0;
      destroy_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      rx_meta     <= link.rxd;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      rx_state    <= rx_next;
      rx_cnt      <= rx_cnt_clr ? '0 : rx_cnt + CW'(1);
      cmd_valid_q <= rx_accept;
      frame_err_q <= rx_ferr;
      hdr_err_q   <= rx_herr;
      if (rx_state == RX_START) rx_bit <= '0;
      else if (rx_shift)        rx_bit <= rx_bit + 3'd1;
      if (rx_shift) rx_byte <= {rx_sync, rx_byte[7:1]};
      // Decoded levels and the cmd_valid pulse appear together, one cycle after the stop sample.
      if (rx_accept) begin
        moving_q  <= rx_byte[3:0];
        place_q   <= rx_byte[4];
        destroy_q <= rx_byte[5];
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t     tx_state, tx_next;
  logic [PW-1:0] per_cnt;
  logic          tick, trigger, launch, pending;
  logic [3:0]    last_sent;
  logic [7:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_cnt_clr, tx_advance, txd_c;

  assign tick    = (per_cnt == PER_LAST);
  assign trigger = tick | (link.detector != last_sent);
  assign launch  = (tx_state == TX_IDLE) & pending;

  always_comb begin
    tx_next    = tx_state;
    tx_cnt_clr = 1'b0;
    tx_advance = 1'b0;
    txd_c      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (pending) begin
          tx_next    = TX_START;
          tx_cnt_clr = 1'b1;
        end
      end
      TX_START: begin
        txd_c = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_next    = TX_DATA;
          tx_cnt_clr = 1'b1;
        end
      end
      TX_DATA: begin
        txd_c = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_clr = 1'b1;
          tx_advance = 1'b1;
          if (tx_bit == 3'd7) tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_next    = TX_IDLE;
          tx_cnt_clr = 1'b1;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      per_cnt   <= '0;
      pending   <= 1'b0;
      last_sent <= '0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else begin
      tx_state <= tx_next;
      per_cnt  <= tick ? '0 : per_cnt + PW'(1);
      tx_cnt   <= tx_cnt_clr ? '0 : tx_cnt + CW'(1);
      // The launch cycle always clears; a trigger only sticks when it arrives outside it.
      if (launch)       pending <= 1'b0;
      else if (trigger) pending <= 1'b1;
      if (launch) begin
        tx_shift  <= {4'b0000, link.detector};
        last_sent <= link.detector;
      end else if (tx_advance) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
      end
      if (tx_state == TX_START) tx_bit <= '0;
      else if (tx_advance)      tx_bit <= tx_bit + 3'd1;
    end
  end

  assign link.txd             = txd_c;
  assign link.tx_busy         = (tx_state != TX_IDLE);
  assign link.moving_state    = moving_q;
  assign link.place_barrier   = place_q;
  assign link.destroy_barrier = destroy_q;
  assign link.cmd_valid       = cmd_valid_q;
  assign link.frame_err       = frame_err_q;
  assign link.hdr_err         = hdr_err_q;
  assign link.rx_dbg          = rx_state;
  assign link.tx_dbg          = tx_state;

endmodule

// File: doc/car_link_responder.md
Name: car_link_responder

Overview:
- Far end of the car-control serial link: the simulated-vehicle side.
- Receives 8N1 UART command bytes of the form {2'b10, destroy_barrier, place_barrier, moving_state[3:0]} and decodes them into held control levels.
- Returns a detector status byte {4'b0000, back, right, left, front} periodically, and immediately whenever any detector input changes.
- Contains its own bit-rate divider, RX framer, command decoder and TX scheduler/serializer.

Parameters:
CLK_FREQ, 100000000, sys_clk frequency in Hz
BAUD, 9600, serial bit rate; BIT_CYC = CLK_FREQ/BAUD (integer division), must be >= 4
STATUS_PERIOD, 1000000, sys_clk cycles between periodic status transmissions (>= 11*BIT_CYC)

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rxd  in  1  serial command input, idle high, asynchronous to sys_clk
txd  out  1  serial status output, idle high
detector  in  4  {back, right, left, front}; level inputs, synchronous to sys_clk
moving_state  out  4  last accepted command bits [3:0]
place_barrier  out  1  last accepted command bit 4
destroy_barrier  out  1  last accepted command bit 5
cmd_valid  out  1  one-cycle pulse when a command byte is accepted
frame_err  out  1  one-cycle pulse on bad start or stop bit
hdr_err  out  1  one-cycle pulse on a good frame with byte[7:6] != 2'b10
tx_busy  out  1  high while a status frame is on txd

Behaviour:
Reset (asynchronous, while rst=1):
- txd=1; moving_state=0; place_barrier=0; destroy_barrier=0.
- All pulses and tx_busy = 0; FSMs return to IDLE; period counter = 0; last_sent = 0.
- Reset mid-frame abandons the frame: txd returns to 1 immediately, and the partial RX byte is discarded.

RX input and state machine:
- rxd passes through a 2-FF synchronizer (reset value 1); falling-edge detection uses the synchronized value.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: on synchronized falling edge, enter START and clear the bit counter.
- START: at BIT_CYC/2 cycles, sample. If low, go to DATA and restart the counter. If high, pulse frame_err and return to IDLE (glitch).
- DATA: sample every BIT_CYC cycles, 8 bits, LSB first.
- STOP: sample after BIT_CYC cycles.
  - Stop bit 0: frame_err pulse, byte discarded, return to IDLE.
  - Stop bit 1, byte[7:6]==2'b10: on the next cycle, moving_state<=byte[3:0], place_barrier<=byte[4], destroy_barrier<=byte[5], and cmd_valid pulses in that same cycle.
  - Stop bit 1, other header: hdr_err pulse, outputs unchanged.
- Returns to IDLE right after the stop sample, so back-to-back frames are accepted.
- Decoded outputs hold their values until the next accepted command.

TX scheduling:
- Free-running period counter runs 0..STATUS_PERIOD-1; wrap produces tick.
- pending flag: set on tick, or when detector != last_sent (checked every cycle).
- When TX is IDLE and pending=1:
  - snapshot detector into the shift register and into last_sent;
  - clear pending;
  - start the frame on the next cycle.
- Set-and-clear in the same cycle: set wins only if it occurs while TX is busy. The start cycle itself clears.
- Detector changes during a frame do not alter the frame in flight; they set pending, so a follow-up frame is sent.

TX frame:
- Start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BIT_CYC cycles. Frame = 10*BIT_CYC cycles.
- tx_busy is high from the start bit's first cycle through the stop bit's last cycle.
- At most one queued request; multiple triggers during a busy frame collapse into one.

Independence and latency:
- RX and TX run fully independently, so full duplex is supported.
- Latency from the rxd stop-bit centre to cmd_valid: 1 cycle after the stop sample, plus 2 cycles of synchronizer delay on the path.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (BIT_CYC=10). Send byte 0xA5 on rxd -> cmd_valid pulses once; moving_state=4'h5, place_barrier=0, destroy_barrier=1; no error pulses.
- Send 0x65 (header 01) -> hdr_err pulses once; outputs keep their previous values. Then send 0x9F -> moving_state=4'hF, place_barrier=1, destroy_barrier=0.
- Frame with stop bit forced 0 -> frame_err pulses; outputs unchanged. Then a 1-cycle low glitch on rxd -> frame_err pulses; RX back in IDLE; the next valid frame is accepted.
- STATUS_PERIOD=500 with detector=4'b0101 held -> every 500 cycles txd carries 0,1,0,1,0,0,0,0,0,1 with 10 cycles per bit; tx_busy is high for 100 cycles.
- detector changes 0000->0010 mid-frame -> the current frame completes unchanged; the next frame starts within 2 cycles of the stop bit ending and carries 0x02.
- Assert rst during RX bit 4 and TX bit 3 -> txd=1 and all outputs 0 immediately. After release, a fresh 0x83 frame is decoded to moving_state=4'h3.
